ws2812_frame_ctrl: RTL and testbench
====================================

Name: ws2812_frame_ctrl

Overview:
- Frame sequencer for the WS2812 single-bit waveform generator.
- Holds a small pixel buffer of 24-bit GRB words and streams them MSB-first into the generator's data input, one bit per 250-cycle bit slot, advancing on the generator's dv pulse.
- After the last bit, it gates the LED line low for a latch (reset) period counted in bit slots, then reports done.
- Sits between the host/pattern logic (buffer writes, start) and the bit waveform generator driving the LED pin.

Parameters:
- LED_NUM, 8, number of LEDs in the chain (>=1).
- ADDR_W, 3, pixel buffer address width; 2**ADDR_W >= LED_NUM.
- RESET_SLOTS, 64, latch period length in bit slots (64 x 250 cycles ≈ 64.6 us at 247.5 MHz, which meets the >50 us WS2812 requirement).

Ports:
- clk  in  1  system clock, 247.5 MHz.
- restn  in  1  asynchronous active-low reset.
- wr_en  in  1  pixel buffer write strobe.
- wr_addr  in  ADDR_W  pixel index; writes with wr_addr >= LED_NUM are ignored.
- wr_data  in  24  pixel word {G[7:0],R[7:0],B[7:0]}.
- start  in  1  frame start request; single-cycle pulse or level.
- busy  out  1  high from the cycle after an accepted start until done.
- done  out  1  one-cycle pulse at frame end.
- bit_data  out  1  bit value to the generator's data input.
- dv_in  in  1  generator bit-slot boundary pulse, one cycle per 250 clocks.
- ws_in  in  1  generator waveform output.
- led_out  out  1  LED pin; registered ws_in AND gate.

Behaviour:
- Reset values: busy=0, done=0, bit_data=0, led_out=0, gate=0, state=IDLE, all counters=0. Pixel buffer contents are not reset; they power up as don't-care.
- Pixel buffer: LED_NUM x 24 registers. Writes are accepted in every state. A pixel word is copied into the 24-bit shift register when that pixel is loaded. Writes to a pixel after its load do not affect the current frame; writes to later pixels do.
- FSM states: IDLE, SYNC, SEND, LATCH.
- IDLE: start=1 -> SYNC; busy=1 from the next cycle. A dv_in in the same cycle as start is ignored.
- SYNC: wait for dv_in. On dv_in:
  - load pixel 0 into the shift register;
  - bit_data=pix0[23], gate=1;
  - bit_cnt=0, pix_cnt=0;
  - -> SEND.
- SEND, on each dv_in:
  - bit_cnt<23: shift left, bit_data=next bit, bit_cnt+1.
  - bit_cnt=23 and pix_cnt<LED_NUM-1: pix_cnt+1, load the next pixel, bit_data=its bit 23, bit_cnt=0.
  - bit_cnt=23 and pix_cnt=LED_NUM-1: gate=0, bit_data=0, slot_cnt=0, -> LATCH.
- LATCH, on each dv_in: slot_cnt+1. On the dv_in where slot_cnt=RESET_SLOTS-1: done=1 for one cycle, busy=0 in the same cycle, -> IDLE.
- Between dv_in pulses, bit_data and gate hold their values. All bit transitions occur only on dv_in.
- led_out is registered: led_out <= ws_in & gate. This adds one clock of latency relative to ws_in; the latency is uniform, so the T0H/T1H widths are preserved.
- Frame length: 1 sync wait + 24*LED_NUM bit slots + RESET_SLOTS latch slots. busy stays high throughout.
- start while busy=1 is ignored; there is no queuing. start high in the cycle done pulses is ignored; a new frame requires start while in IDLE.
- Asynchronous reset mid-frame: everything returns to reset values immediately and led_out goes low. The partial frame is abandoned; the next frame resends from pixel 0.
- Counter widths: bit_cnt 5 bits, pix_cnt ADDR_W bits, slot_cnt clog2(RESET_SLOTS)+1 bits. No wrap occurs within legal parameters.

Test Plan:
- LED_NUM=2, pix0=24'hFF0000, pix1=24'h00000F; start -> bit_data sequence over 48 dv_in pulses is 8 ones, 16 zeros, 20 zeros, 4 ones. led_out high-time is 200 clocks for 1-bits and 50 clocks for 0-bits.
- Default params; count dv_in from SYNC exit to done -> exactly 192 SEND slots + 64 LATCH slots. led_out stays 0 for all 64x250 latch cycles. done is one cycle wide and busy falls in the same cycle.
- start pulsed at cycles 10, 500 and 30000 during one frame -> only one frame is sent. busy stays high continuously and done pulses once.
- Write pix1=24'h123456 while pixel 0 is shifting, and write pix0 during pixel 1 -> the frame carries the new pix1 and the old pix0.
- Assert restn=0 at bit 30 of the frame -> led_out, busy and bit_data go to 0 immediately. A new start after release resends from pix0 bit 23.
- Write with wr_addr=7 when LED_NUM=6, then send -> the frame is unchanged and 144 bits are sent.

Source files
------------

// File: rtl/ws2812_frame_ctrl.sv
// Frame sequencer for a WS2812 bit waveform generator: streams a GRB pixel buffer MSB-first,
// one bit per generator slot, then holds the line low for a latch period and pulses done.
module ws2812_frame_ctrl #(
  parameter int unsigned LED_NUM     = 8,
  parameter int unsigned ADDR_W      = 3,
  parameter int unsigned RESET_SLOTS = 64
) (
  input  logic              clk,
  input  logic              restn,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [23:0]       wr_data,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              bit_data,
  input  logic              dv_in,
  input  logic              ws_in,
  output logic              led_out
);

  localparam int unsigned       SlotW    = $clog2(RESET_SLOTS) + 1;
  localparam logic [ADDR_W-1:0] LastPix  = ADDR_W'(LED_NUM - 1);
  localparam logic [SlotW-1:0]  LastSlot = SlotW'(RESET_SLOTS - 1);

  typedef enum logic [1:0] {StIdle, StSync, StSend, StLatch} state_e;

  state_e                    state;
  logic [LED_NUM-1:0][23:0]  pix_mem;
  logic [23:0]               shift;
  logic [4:0]                bit_cnt;
  logic [ADDR_W-1:0]         pix_cnt;
  logic [SlotW-1:0]          slot_cnt;
  logic                      gate;
  logic [ADDR_W-1:0]         next_idx;
  logic [23:0]               next_pix;

  // Out-of-range addresses match no entry and are dropped; buffer is intentionally not reset.
  always_ff @(posedge clk) begin
    for (int i = 0; i < int'(LED_NUM); i++) begin
      if (wr_en && (wr_addr == ADDR_W'(i))) begin
        pix_mem[i] <= wr_data;
      end
    end
  end

  assign next_idx = pix_cnt + ADDR_W'(1);

  always_comb begin
    next_pix = pix_mem[0];
    for (int i = 0; i < int'(LED_NUM); i++) begin
      if (next_idx == ADDR_W'(i)) begin
        next_pix = pix_mem[i];
      end
    end
  end

  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      state    <= StIdle;
      busy     <= 1'b0;
      done     <= 1'b0;
      bit_data <= 1'b0;
      gate     <= 1'b0;
      shift    <= '0;
      bit_cnt  <= '0;
      pix_cnt  <= '0;
      slot_cnt <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        StIdle: begin
          // The cycle done is high still sits in IDLE but must not restart the frame.
          if (start && !done) begin
            state <= StSync;
            busy  <= 1'b1;
          end
        end
        StSync: begin
          if (dv_in) begin
            shift    <= pix_mem[0];
            bit_data <= pix_mem[0][23];
            gate     <= 1'b1;
            bit_cnt  <= '0;
            pix_cnt  <= '0;
            state    <= StSend;
          end
        end
        StSend: begin
          if (dv_in) begin
            if (bit_cnt != 5'd23) begin
              shift    <= shift << 1;
              bit_data <= shift[22];
              bit_cnt  <= bit_cnt + 5'd1;
            end else if (pix_cnt != LastPix) begin
              pix_cnt  <= next_idx;
              shift    <= next_pix;
              bit_data <= next_pix[23];
              bit_cnt  <= '0;
            end else begin
              gate     <= 1'b0;
              bit_data <= 1'b0;
              slot_cnt <= '0;
              state    <= StLatch;
            end
          end
        end
        StLatch: begin
          if (dv_in) begin
            slot_cnt <= slot_cnt + SlotW'(1);
            if (slot_cnt == LastSlot) begin
              done  <= 1'b1;
              busy  <= 1'b0;
              state <= StIdle;
            end
          end
        end
      endcase
    end
  end

  // One clock of uniform latency keeps the generator's high-time widths intact.
  always_ff @(posedge clk or negedge restn) begin
    if (!restn) begin
      led_out <= 1'b0;
    end else begin
      led_out <= ws_in & gate;
    end
  end

endmodule

// File: tb/tb_ws2812_frame_ctrl.sv
// Randomized scoreboard bench for ws2812_frame_ctrl with a behavioural bit-slot generator.
module tb_ws2812_frame_ctrl;

  localparam int unsigned LED   = 6;
  localparam int unsigned AW    = 3;
  localparam int unsigned RS    = 16;
  localparam int          PER   = 20;
  localparam int          T1H   = 16;
  localparam int          T0H   = 4;
  localparam int          NBITS = 24 * LED;
  localparam int          TOTAL = NBITS + RS + 1;
  localparam int          LIMIT = (TOTAL + 3) * PER + 100;

  logic          clk;
  logic          restn;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [23:0]   wr_data;
  logic          start;
  logic          busy;
  logic          done;
  logic          bit_data;
  logic          dv_in;
  logic          ws_in;
  logic          led_out;

  ws2812_frame_ctrl #(
    .LED_NUM    (LED),
    .ADDR_W     (AW),
    .RESET_SLOTS(RS)
  ) dut (
    .clk     (clk),
    .restn   (restn),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .start   (start),
    .busy    (busy),
    .done    (done),
    .bit_data(bit_data),
    .dv_in   (dv_in),
    .ws_in   (ws_in),
    .led_out (led_out)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [23:0] ref_buf [LED];
  logic [23:0] img     [LED];
  logic        exp_q   [$];

  int   edge_n    = 0;
  bit   pend_m    = 0;
  int   hi_cnt    = 0;
  int   exp_hi    = 0;
  bit   prev_done = 0;
  int   done_cnt  = 0;
  int   gcnt      = 0;
  logic cur_bit   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Generator model: dv_in once per PER clocks, ws_in high T1H/T0H clocks for the latched bit.
  initial begin
    dv_in = 1'b0;
    ws_in = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      gcnt  = (gcnt + 1) % PER;
      dv_in = (gcnt == 0);
      if (gcnt == 1) cur_bit = bit_data;
      ws_in = (gcnt >= 1) && (gcnt <= (cur_bit ? T1H : T0H));
    end
  end

  // Monitor: every dv_in taken while busy is one slot boundary of the frame.
  initial begin
    logic eb;
    forever begin
      @(negedge clk);
      if (!restn) begin
        exp_q.delete();
        edge_n = 0;
        pend_m = 0;
        hi_cnt = 0;
      end else begin
        if (prev_done) check("done_one_cycle", done, 0);
        if (pend_m) begin
          edge_n++;
          if (edge_n >= 2) check("led_high_time", hi_cnt, exp_hi);
          hi_cnt = 0;
          if (edge_n <= NBITS) begin
            if (exp_q.size() == 0) begin
              check("scoreboard_nonempty", 0, 1);
            end else begin
              eb = exp_q.pop_front();
              check("bit_data", bit_data, eb);
              exp_hi = eb ? T1H : T0H;
            end
          end else begin
            exp_hi = 0;
            if (edge_n == NBITS + 1) check("bit_data_latch", bit_data, 0);
            if (edge_n == TOTAL) begin
              check("done_at_end", done, 1);
              check("busy_fall_with_done", busy, 0);
              edge_n = 0;
            end else begin
              check("no_early_done", done, 0);
            end
          end
        end
        if (led_out) hi_cnt++;
        if (done) done_cnt++;
        prev_done = done;
        pend_m    = dv_in && busy;
      end
    end
  end

  task automatic do_write(input logic [AW-1:0] a, input logic [23:0] d);
    @(negedge clk);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    @(negedge clk);
    wr_en = 1'b0;
    if (32'(a) < LED) ref_buf[a] = d;
  endtask

  task automatic push_img();
    for (int p = 0; p < int'(LED); p++) begin
      for (int b = 23; b >= 0; b--) exp_q.push_back(img[p][b]);
    end
  endtask

  // mode 0: plain, 1: extra starts + start on done, 2: mid-frame writes, 3: reset at bit 30
  task automatic run_frame(input int mode);
    int   cyc;
    int   ndv;
    int   d0;
    bit   pend;
    bit   seen_done;
    bit   busy_drop;
    bit   w1;
    bit   w0;
    logic [23:0] nd;
    img = ref_buf;
    if (mode == 2) img[1] = 24'h123456;
    push_img();
    d0 = done_cnt;
    repeat ($urandom_range(0, PER - 1)) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0; ndv = 0; pend = 0; seen_done = 0; busy_drop = 0; w1 = 0; w0 = 0;
    while (!seen_done && cyc < LIMIT) begin
      @(negedge clk);
      cyc++;
      wr_en = 1'b0;
      start = 1'b0;
      if (pend) ndv++;
      pend = dv_in && busy;
      if (!busy && !done) busy_drop = 1;
      if (done) seen_done = 1;
      if (mode == 1) begin
        if (cyc == 10 || cyc == 500 || cyc == (TOTAL - 3) * PER || seen_done) start = 1'b1;
      end else if (mode == 2) begin
        if (ndv == 6 && !w1) begin
          w1 = 1; wr_en = 1'b1; wr_addr = 1; wr_data = 24'h123456;
          ref_buf[1] = 24'h123456;
        end else if (ndv == 31 && !w0) begin
          nd = 24'($urandom);
          w0 = 1; wr_en = 1'b1; wr_addr = 0; wr_data = nd;
          ref_buf[0] = nd;
        end
      end else if (mode == 3 && ndv == 31) begin
        repeat (3) @(negedge clk);
        check("led_high_before_reset", led_out, 1);
        #3 restn = 1'b0;
        #1;
        check("reset_led_out", led_out, 0);
        check("reset_busy", busy, 0);
        check("reset_bit_data", bit_data, 0);
        repeat (2) @(negedge clk);
        #3 restn = 1'b1;
        return;
      end
    end
    if (!seen_done) check("frame_timeout", cyc, LIMIT - 1);
    @(negedge clk);
    start = 1'b0;
    check("done_pulses", done_cnt - d0, 1);
    check("busy_continuous", busy_drop, 0);
    check("scoreboard_drained", exp_q.size(), 0);
    if (mode == 1) begin
      repeat (3) @(negedge clk);
      check("start_on_done_ignored", busy, 0);
    end
  endtask

  initial begin
    restn   = 1'b0;
    start   = 1'b0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    repeat (3) @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_bit_data", bit_data, 0);
    check("rst_led_out", led_out, 0);
    #3 restn = 1'b1;

    do_write(0, 24'hFF0000);
    do_write(1, 24'h00000F);
    for (int i = 2; i < int'(LED); i++) do_write(AW'(i), 24'($urandom));
    do_write(7, 24'hABCDEF);
    do_write(6, 24'h5A5A5A);
    run_frame(1);

    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < 8; i++) do_write(AW'($urandom_range(0, 7)), 24'($urandom));
      run_frame(0);
    end

    run_frame(2);
    run_frame(3);
    repeat (5) @(negedge clk);
    check("idle_after_reset", busy, 0);
    run_frame(0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
